// File: rtl/dram_req_bridge.sv
// Bridges single MMU load/store strobes onto a req/ack 32-bit word port,
// splitting word-crossing accesses into two beats and aligning/extending load data.
module dram_req_bridge #(
  parameter int ADDR_WIDTH  = 27,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           w_dram_addr,
  input  logic [31:0]           w_dram_wdata,
  input  logic [2:0]            w_dram_ctrl,
  input  logic                  w_dram_we_t,
  input  logic                  w_dram_le,
  output logic                  w_dram_busy,
  output logic [31:0]           w_dram_odata,
  output logic                  w_set_dram_le,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_wstrb,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, DONE = 2'd3} state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: size_mask = 4'b0001;
      3'd1, 3'd5: size_mask = 4'b0011;
      default:    size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic ctrl_legal(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ctrl_legal = 1'b1;
      default:                      ctrl_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'd0:    extend_load = {{24{raw[7]}}, raw[7:0]};
      3'd1:    extend_load = {{16{raw[15]}}, raw[15:0]};
      3'd4:    extend_load = {24'd0, raw[7:0]};
      3'd5:    extend_load = {16'd0, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

  state_e                state_r, state_next_s;
  logic [ADDR_WIDTH+1:0] addr_r, sel_addr_s;
  logic [31:0]           wdata_r, sel_wdata_s, beat0_rdata_r, raw_load_s;
  logic [2:0]            ctrl_r;
  logic [3:0]            mask_r, sel_mask_s, in_mask_s;
  logic                  we_r, sel_we_s, split_r;
  logic [7:0]            in_span_s, sel_span_s;
  logic [2:0]            sel_rshift_s, ld_rshift_s;
  logic                  strobe_s, accept_s, in_cross_s, err_set_s, finish_s;
  logic                  req_s, mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s, sel_word_s;
  logic [31:0]           mem_wdata_s;
  logic [3:0]            mem_wstrb_s;
  logic                  busy_r, set_le_r, req_r, mem_we_r, err_r;
  logic [31:0]           odata_r, mem_wdata_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [3:0]            mem_wstrb_r;
  logic                  unused_addr_s;

  assign unused_addr_s = ^w_dram_addr[31:ADDR_WIDTH+2];

  assign strobe_s   = w_dram_le | w_dram_we_t;
  assign accept_s   = (state_r == IDLE) & strobe_s;
  assign in_mask_s  = size_mask(w_dram_ctrl);
  assign in_span_s  = {4'b0000, in_mask_s} << w_dram_addr[1:0];
  assign in_cross_s = |in_span_s[7:4];
  assign err_set_s  = (w_dram_le & w_dram_we_t) | ((state_r != IDLE) & strobe_s)
                    | (accept_s & ~ctrl_legal(w_dram_ctrl))
                    | (accept_s & in_cross_s & ~ALLOW_SPLIT);

  // Beat fields come straight from the inputs on the accept edge, from the latched copy afterwards.
  always_comb begin
    if (accept_s) begin
      sel_addr_s  = w_dram_addr[ADDR_WIDTH+1:0];
      sel_wdata_s = w_dram_wdata;
      sel_mask_s  = in_mask_s;
      sel_we_s    = w_dram_we_t;
    end else begin
      sel_addr_s  = addr_r;
      sel_wdata_s = wdata_r;
      sel_mask_s  = mask_r;
      sel_we_s    = we_r;
    end
  end

  assign sel_word_s   = sel_addr_s[ADDR_WIDTH+1:2];
  assign sel_span_s   = {4'b0000, sel_mask_s} << sel_addr_s[1:0];
  assign sel_rshift_s = 3'd4 - {1'b0, sel_addr_s[1:0]};
  assign ld_rshift_s  = 3'd4 - {1'b0, addr_r[1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = BEAT0; else state_next_s = IDLE;
      BEAT0:   if (i_mem_ack) state_next_s = split_r ? BEAT1 : DONE; else state_next_s = BEAT0;
      BEAT1:   if (i_mem_ack) state_next_s = DONE; else state_next_s = BEAT1;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Memory-port values for the state being entered; registered below so they line up with it.
  always_comb begin
    req_s       = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_WIDTH{1'b0}};
    mem_wdata_s = 32'd0;
    mem_wstrb_s = 4'd0;
    case (state_next_s)
      BEAT0: begin
        req_s      = 1'b1;
        mem_we_s   = sel_we_s;
        mem_addr_s = sel_word_s;
        if (sel_we_s) begin
          mem_wstrb_s = sel_span_s[3:0];
          mem_wdata_s = sel_wdata_s << {sel_addr_s[1:0], 3'b000};
        end else begin
          mem_wstrb_s = 4'd0;
          mem_wdata_s = 32'd0;
        end
      end
      BEAT1: begin
        req_s      = 1'b1;
        mem_we_s   = sel_we_s;
        mem_addr_s = sel_word_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (sel_we_s) begin
          mem_wstrb_s = sel_mask_s >> sel_rshift_s;
          mem_wdata_s = sel_wdata_s >> {sel_rshift_s, 3'b000};
        end else begin
          mem_wstrb_s = 4'd0;
          mem_wdata_s = 32'd0;
        end
      end
      default: req_s = 1'b0;
    endcase
  end

  assign finish_s   = ((state_r == BEAT0) | (state_r == BEAT1)) & (state_next_s == DONE);
  assign raw_load_s = split_r ? ((beat0_rdata_r >> {addr_r[1:0], 3'b000})
                                 | (i_mem_rdata << {ld_rshift_s, 3'b000}))
                              : (i_mem_rdata >> {addr_r[1:0], 3'b000});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_r        <= {(ADDR_WIDTH+2){1'b0}};
      wdata_r       <= 32'd0;
      ctrl_r        <= 3'd0;
      mask_r        <= 4'd0;
      we_r          <= 1'b0;
      split_r       <= 1'b0;
      beat0_rdata_r <= 32'd0;
    end else begin
      if (accept_s) begin
        addr_r  <= w_dram_addr[ADDR_WIDTH+1:0];
        wdata_r <= w_dram_wdata;
        ctrl_r  <= w_dram_ctrl;
        mask_r  <= in_mask_s;
        we_r    <= w_dram_we_t;
        split_r <= in_cross_s & ALLOW_SPLIT;
      end
      if ((state_r == BEAT0) && i_mem_ack) beat0_rdata_r <= i_mem_rdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_r      <= 1'b0;
      req_r       <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= 32'd0;
      mem_wstrb_r <= 4'd0;
      set_le_r    <= 1'b0;
      odata_r     <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      busy_r      <= (state_next_s != IDLE);
      req_r       <= req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_wstrb_r <= mem_wstrb_s;
      set_le_r    <= finish_s & ~we_r;
      if (finish_s && !we_r) odata_r <= extend_load(ctrl_r, raw_load_s);
      err_r       <= err_r | err_set_s;
    end
  end

  assign w_dram_busy   = busy_r;
  assign w_dram_odata  = odata_r;
  assign w_set_dram_le = set_le_r;
  assign o_mem_req     = req_r;
  assign o_mem_we      = mem_we_r;
  assign o_mem_addr    = mem_addr_r;
  assign o_mem_wdata   = mem_wdata_r;
  assign o_mem_wstrb   = mem_wstrb_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_dram_req_bridge.sv
// Scoreboard bench: a byte-level model predicts memory beats and load results,
// a responder checks/acks beats, a monitor checks completed loads.
module tb_dram_req_bridge;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] w_dram_addr, w_dram_wdata, w_dram_odata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_we_t, w_dram_le, w_dram_busy, w_set_dram_le;
  logic        o_mem_req, o_mem_we, i_mem_ack, o_err;
  logic [26:0] o_mem_addr;
  logic [31:0] o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_wstrb;

  typedef struct {
    logic [26:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] load_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_delay = 0;
  int          wcnt = 0;

  always #5 CLK = ~CLK;

  dram_req_bridge #(.ADDR_WIDTH(27), .ALLOW_SPLIT(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_we_t(w_dram_we_t), .w_dram_le(w_dram_le), .w_dram_busy(w_dram_busy),
    .w_dram_odata(w_dram_odata), .w_set_dram_le(w_set_dram_le),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-by-byte model: each accessed byte lands in whichever word it falls in.
  task automatic push_model(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1);
    beat_t       b0, b1;
    int          n, lane;
    logic [31:0] ba, res;
    logic [26:0] w0;
    bit          two;
    n  = (ctrl == 3'd0 || ctrl == 3'd4) ? 1 : ((ctrl == 3'd1 || ctrl == 3'd5) ? 2 : 4);
    w0 = addr[28:2];
    b0 = '{addr: w0, we: we, wstrb: 4'd0, wdata: 32'd0, rdata: rd0};
    b1 = '{addr: w0 + 27'd1, we: we, wstrb: 4'd0, wdata: 32'd0, rdata: rd1};
    two = 1'b0;
    res = 32'd0;
    for (int i = 0; i < n; i++) begin
      ba   = addr + 32'(i);
      lane = int'(ba[1:0]);
      if (ba[28:2] != w0) begin
        two = 1'b1;
        if (we) begin
          b1.wstrb[lane] = 1'b1;
          b1.wdata[lane*8 +: 8] = wdata[i*8 +: 8];
        end
        res[i*8 +: 8] = rd1[lane*8 +: 8];
      end else begin
        if (we) begin
          b0.wstrb[lane] = 1'b1;
          b0.wdata[lane*8 +: 8] = wdata[i*8 +: 8];
        end
        res[i*8 +: 8] = rd0[lane*8 +: 8];
      end
    end
    case (ctrl)
      3'd0:    res = {{24{res[7]}}, res[7:0]};
      3'd1:    res = {{16{res[15]}}, res[15:0]};
      3'd4:    res = {24'd0, res[7:0]};
      3'd5:    res = {16'd0, res[15:0]};
      default: res = res;
    endcase
    beat_q.push_back(b0);
    if (two) beat_q.push_back(b1);
    if (!we) load_q.push_back(res);
  endtask

  // Memory responder: checks every requested cycle against the expected beat, acks after ack_delay.
  initial begin
    beat_t cur;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'd0;
    forever begin
      @(negedge CLK);
      i_mem_ack = 1'b0;
      if (RST !== 1'b0 || o_mem_req !== 1'b1) begin
        wcnt = 0;
      end else if (beat_q.size() == 0) begin
        chk("beat_unexpected", {31'd0, o_mem_req}, 32'd0);
        i_mem_ack = 1'b1;
      end else begin
        cur = beat_q[0];
        chk("beat_addr", {5'd0, o_mem_addr}, {5'd0, cur.addr});
        chk("beat_we", {31'd0, o_mem_we}, {31'd0, cur.we});
        chk("beat_wstrb", {28'd0, o_mem_wstrb}, {28'd0, cur.wstrb});
        if (cur.we) chk("beat_wdata", o_mem_wdata, cur.wdata);
        if (wcnt < ack_delay) begin
          wcnt++;
        end else begin
          void'(beat_q.pop_front());
          i_mem_rdata = cur.rdata;
          i_mem_ack   = 1'b1;
          wcnt        = 0;
        end
      end
    end
  end

  // Load monitor: every completion pulse must match the oldest expected load.
  initial begin
    forever begin
      @(negedge CLK);
      if (w_set_dram_le === 1'b1) begin
        if (load_q.size() == 0) chk("le_unexpected", {31'd0, w_set_dram_le}, 32'd0);
        else chk("load_odata", w_dram_odata, load_q.pop_front());
      end
    end
  end

  task automatic run_access(input logic we, input logic both, input logic [2:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int delay, input int exp_lat, input logic inject);
    int lat;
    push_model(we | both, ctrl, addr, wdata, rd0, rd1);
    ack_delay = delay;
    @(posedge CLK); #1;
    w_dram_addr  = addr;
    w_dram_wdata = wdata;
    w_dram_ctrl  = ctrl;
    w_dram_we_t  = we | both;
    w_dram_le    = ~we | both;
    @(posedge CLK); #1;
    w_dram_we_t = 1'b0;
    w_dram_le   = 1'b0;
    lat = 1;
    if (inject) begin
      w_dram_le   = 1'b1;
      w_dram_addr = 32'h0000_0FF0;
      w_dram_ctrl = 3'd2;
      @(posedge CLK); #1;
      w_dram_le = 1'b0;
      lat++;
    end
    while (w_dram_busy === 1'b1 && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("busy_release", {31'd0, w_dram_busy}, 32'd0);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    chk("beatq_drained", beat_q.size(), 0);
    chk("loadq_drained", load_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    RST = 1'b1;
    w_dram_addr = 32'd0; w_dram_wdata = 32'd0; w_dram_ctrl = 3'd0;
    w_dram_we_t = 1'b0;  w_dram_le = 1'b0;
    #1;
    chk("rst_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_busy", {31'd0, w_dram_busy}, 32'd0);
    chk("rst_odata", w_dram_odata, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Load W, immediate ack
    run_access(1'b0, 1'b0, 3'd2, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 32'd0, 0, 3, 1'b0);
    chk("err_clean", {31'd0, o_err}, 32'd0);
    // Store B at offset 3; odata must hold the previous load
    run_access(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0000_00AB, 32'd0, 32'd0, 0, 3, 1'b0);
    chk("store_keeps_odata", w_dram_odata, 32'hDEAD_BEEF);
    // Split halfword loads, signed and unsigned
    run_access(1'b0, 1'b0, 3'd1, 32'h0000_0203, 32'd0, 32'h8012_3456, 32'h789A_BCFF, 0, 4, 1'b0);
    run_access(1'b0, 1'b0, 3'd5, 32'h0000_0203, 32'd0, 32'h8012_3456, 32'h789A_BCFF, 0, 4, 1'b0);
    // Byte loads at offset 1
    run_access(1'b0, 1'b0, 3'd0, 32'h0000_0051, 32'd0, 32'h0000_F100, 32'd0, 2, 0, 1'b0);
    run_access(1'b0, 1'b0, 3'd4, 32'h0000_0051, 32'd0, 32'h0000_F100, 32'd0, 0, 3, 1'b0);
    // Split store W at offset 2 with slow acks
    run_access(1'b1, 1'b0, 3'd2, 32'h0000_0302, 32'h1122_3344, 32'd0, 32'd0, 5, 0, 1'b0);
    chk("err_still_clean", {31'd0, o_err}, 32'd0);
    // Both strobes together: store runs, error flagged
    run_access(1'b1, 1'b1, 3'd1, 32'h0000_0400, 32'h0000_BEEF, 32'd0, 32'd0, 0, 3, 1'b0);
    chk("err_both_strobes", {31'd0, o_err}, 32'd1);
    // Load strobe while busy is ignored
    run_access(1'b0, 1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'h1234_5678, 32'd0, 3, 0, 1'b1);
    @(posedge CLK); #1;
    chk("ignored_strobe_idle", {31'd0, w_dram_busy}, 32'd0);
    chk("err_busy_strobe", {31'd0, o_err}, 32'd1);
    // Split at the top word address wraps to word 0
    run_access(1'b1, 1'b0, 3'd2, 32'h1FFF_FFFE, 32'hA1B2_C3D4, 32'd0, 32'd0, 0, 4, 1'b0);

    // Reset in the middle of the second beat
    push_model(1'b0, 3'd2, 32'h1FFF_FFFD, 32'd0, 32'h0102_0304, 32'h0506_0708);
    ack_delay = 5;
    @(posedge CLK); #1;
    w_dram_addr = 32'h1FFF_FFFD; w_dram_ctrl = 3'd2; w_dram_le = 1'b1;
    @(posedge CLK); #1;
    w_dram_le = 1'b0;
    cyc = 0;
    while (!(o_mem_req === 1'b1 && o_mem_addr === 27'd0) && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("beat1_reached", {31'd0, o_mem_req}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("abort_req", {31'd0, o_mem_req}, 32'd0);
    chk("abort_busy", {31'd0, w_dram_busy}, 32'd0);
    chk("abort_err", {31'd0, o_err}, 32'd0);
    chk("abort_le", {31'd0, w_set_dram_le}, 32'd0);
    chk("abort_odata", w_dram_odata, 32'd0);
    beat_q.delete();
    load_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;

    // Normal access after the abort
    run_access(1'b0, 1'b0, 3'd2, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 32'd0, 0, 3, 1'b0);
    chk("post_reset_err", {31'd0, o_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_req_bridge.md
Name: dram_req_bridge

Overview:
Sits directly downstream of the MMU's DRAM port. Accepts one load or store per strobe (w_dram_le / w_dram_we_t) with RISC-V funct3 size control. Converts it into one or two 32-bit word transactions on a req/ack memory port, with byte strobes and read-data alignment/extension, and returns w_dram_busy, w_dram_odata and the w_set_dram_le completion pulse to the MMU.

Parameters:
ADDR_WIDTH, 27, width of word address on memory port (byte address bits [ADDR_WIDTH+1:2] used)
ALLOW_SPLIT, 1, 1: word-crossing accesses split into two beats; 0: flagged as error, issued as single truncated beat

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
w_dram_addr  in  32  byte address from MMU
w_dram_wdata  in  32  store data, right-aligned
w_dram_ctrl  in  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (stores use 0/1/2)
w_dram_we_t  in  1  store strobe, 1-cycle
w_dram_le  in  1  load strobe, 1-cycle
w_dram_busy  out  1  transaction in progress
w_dram_odata  out  32  aligned, extended load result
w_set_dram_le  out  1  1-cycle pulse: load data valid
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  write beat
o_mem_addr  out  ADDR_WIDTH  word address
o_mem_wdata  out  32  lane-positioned write data
o_mem_wstrb  out  4  byte enables
i_mem_ack  in  1  beat complete (rdata valid same cycle for reads)
i_mem_rdata  in  32  read word
o_err  out  1  sticky: illegal strobe or misaligned with ALLOW_SPLIT=0

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; o_mem_req drops mid-operation, in-flight beat abandoned.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: strobe latches addr/wdata/ctrl/we; next cycle BEAT0, w_dram_busy=1, o_mem_req=1. Both strobes same cycle: store executes, o_err set.
- Size n = 1/2/4 bytes; off = addr[1:0]; split iff off+n>4 (and ALLOW_SPLIT=1).
- BEAT0: addr = addr[ADDR_WIDTH+1:2]; wstrb = (nmask<<off)[3:0]; wdata = wdata<<(8*off). Req/addr/strobes stable until i_mem_ack. On ack: split -> BEAT1 (req stays high, no deassert cycle) else DONE. Read: bytes captured from rdata.
- BEAT1: addr = word+1, wraps to 0 at 2^ADDR_WIDTH-1; wstrb = nmask>>(4-off); wdata = wdata>>(8*(4-off)). On ack -> DONE.
- Load assembly: beat0 supplies bytes off..3 as low result bytes; beat1 supplies remaining as high bytes. B/H sign-extend from bit 7/15; BU/HU/W zero/no-extend. Undefined ctrl (3,6,7) treated as W, o_err set.
- DONE (1 cycle): o_mem_req=0; loads: w_dram_odata updated, w_set_dram_le=1; w_dram_busy=0 from next cycle (IDLE). w_dram_odata holds until next load completes; stores leave it unchanged.
- Min latency strobe->busy low: 3 cycles single beat, 4 split (ack in first req cycle).
- Strobes while busy: ignored, o_err set. o_err clears only on reset.
- ALLOW_SPLIT=0 and off+n>4: beat0 only, o_err set.

Test Plan:
- Load W at 0x8000_0010, ack immediately, rdata 0xDEADBEEF -> one beat addr 0x4, wstrb 0; w_set_dram_le pulse, odata 0xDEADBEEF, busy high 3 cycles.
- Store B 0xAB at 0x...0003 -> wstrb 0b1000, wdata 0xAB000000, single beat, w_set_dram_le stays 0.
- Load H (ctrl 1) at offset 3, beat0 rdata 0x80xxxxxx, beat1 rdata 0xxxxxxxFF -> two beats, addr N then N+1, odata 0xFFFFFF80; with HU odata 0x0000FF80.
- Store W 0x11223344 at offset 2, ack delayed 5 cycles per beat -> beat0 wstrb 0b1100 wdata 0x33440000, beat1 wstrb 0b0011 wdata 0x00001122; req/addr stable throughout waits.
- Split at top word address (2^27-1) -> beat1 addr 0; assert RST mid-BEAT1 -> req and busy 0 immediately, next access normal.
- w_dram_le while busy, and we_t+le same cycle -> extra strobe ignored, o_err=1, store performed.
